// File: rtl/ssi_abs_encoder_master.sv
// SSI master for absolute encoders, one instance per motor axis.
// Generates the SSI clock, shifts in a DATA_BITS frame MSB first, waits out
// the encoder monoflop, then publishes the position with a 4-bit sequence tag
// and line/monoflop/overrun error flags.
// Optional build macro: SSI_GRAY_DECODE_EN -- when defined, the captured frame
// is Gray-decoded before being published; otherwise it is published raw.
module ssi_abs_encoder_master #(
  parameter int DATA_BITS   = 28,      // frame width, 8..32
  parameter int HALF_PERIOD = 10,      // SSI clock half-period in clk_100m cycles, >= 4
  parameter int READ_PERIOD = 100000,  // auto-read interval in clk_100m cycles
  parameter int MONO_CYCLES = 2500     // monoflop recovery wait after the last rising edge
) (
  input  logic                 clk_100m,
  input  logic                 rst_n_syn,
  input  logic                 auto_en,
  input  logic                 read_req,
  input  logic                 err_clr,
  input  logic                 ssi_d,
  output logic                 ssi_c,
  output logic                 busy,
  output logic [DATA_BITS-1:0] position,
  output logic                 pos_valid,
  output logic [3:0]           seq_cnt,
  output logic                 line_err,
  output logic                 mono_err,
  output logic                 overrun_err
);

  // One down-counter serves both the half-period and the monoflop wait.
  localparam int CNT_MAX = (HALF_PERIOD > MONO_CYCLES) ? HALF_PERIOD : MONO_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(DATA_BITS + 1);
  localparam int TMR_W   = $clog2(READ_PERIOD + 1);

  localparam logic [CNT_W-1:0] HP_LOAD   = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] MONO_LOAD = CNT_W'(MONO_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(READ_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_MONO
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] pos_q, pos_d;
  logic [DATA_BITS-1:0] decoded;
  logic [3:0]           seq_q, seq_d;
  logic                 ssi_c_q, ssi_c_d;
  logic                 line_ok_q, line_ok_d;
  logic                 pv_q, pv_d;
  logic                 line_err_q, line_err_d;
  logic                 mono_err_q, mono_err_d;
  logic                 overrun_q;
  logic [1:0]           sync_q;
  logic                 ssi_d_s;
  logic [TMR_W-1:0]     tmr_q;
  logic                 period_tick;
  logic                 trig_raw;
  logic                 trig_q;
  logic                 ovr_set;
  logic                 busy_w;

  // Two-flop synchroniser for the asynchronous encoder data line.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn) sync_q <= 2'b00;
    else            sync_q <= {sync_q[0], ssi_d};
  end

  assign ssi_d_s = sync_q[1];

  // Free-running read timer; held at zero whenever auto reads are disabled.
  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn)                   tmr_q <= '0;
    else if (!auto_en || period_tick) tmr_q <= '0;
    else                              tmr_q <= tmr_q + 1'b1;
  end

  assign period_tick = auto_en && (tmr_q == TMR_LAST);
  assign trig_raw    = read_req | period_tick;
  assign busy_w      = (state_q != S_IDLE);
  // A trigger already queued for the FSM also counts as busy, so nothing is lost silently.
  assign ovr_set     = trig_raw & (busy_w | trig_q);

  // Trigger register: only a trigger that finds the block idle is queued.
  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn) trig_q <= 1'b0;
    else            trig_q <= trig_raw & ~busy_w & ~trig_q;
  end

  // Sticky overrun flag; a new overrun beats a simultaneous clear.
  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn)   overrun_q <= 1'b0;
    else if (ovr_set) overrun_q <= 1'b1;
    else if (err_clr) overrun_q <= 1'b0;
  end

`ifdef SSI_GRAY_DECODE_EN
  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin : g2b
    logic acc;
    acc = 1'b0;
    for (int i = DATA_BITS - 1; i >= 0; i--) begin
      acc        = acc ^ shift_q[i];
      decoded[i] = acc;
    end
  end
`else
  assign decoded = shift_q;
`endif

  // FSM and datapath state registers; reset drives ssi_c high immediately.
  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      pos_q      <= '0;
      seq_q      <= 4'd0;
      ssi_c_q    <= 1'b1;
      line_ok_q  <= 1'b0;
      pv_q       <= 1'b0;
      line_err_q <= 1'b0;
      mono_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      pos_q      <= pos_d;
      seq_q      <= seq_d;
      ssi_c_q    <= ssi_c_d;
      line_ok_q  <= line_ok_d;
      pv_q       <= pv_d;
      line_err_q <= line_err_d;
      mono_err_q <= mono_err_d;
    end
  end

  // Next-state logic: clock generation, bit capture, monoflop wait, publish.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    pos_d      = pos_q;
    seq_d      = seq_q;
    ssi_c_d    = ssi_c_q;
    line_ok_d  = line_ok_q;
    pv_d       = 1'b0;
    line_err_d = line_err_q;
    mono_err_d = mono_err_q;

    case (state_q)
      S_IDLE: begin
        if (trig_q) begin
          line_ok_d = ssi_d_s;
          ssi_c_d   = 1'b0;       // start edge, not sampled
          cnt_d     = HP_LOAD;
          bit_d     = '0;
          state_d   = S_LOW;
        end
      end
      S_LOW: begin
        if (cnt_q == '0) begin
          ssi_c_d = 1'b1;
          if (bit_q == BIT_LAST) begin
            cnt_d   = MONO_LOAD;
            state_d = S_MONO;
          end else begin
            cnt_d   = HP_LOAD;
            state_d = S_HIGH;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt_q == '0) begin
          ssi_c_d = 1'b0;
          shift_d = {shift_q[DATA_BITS-2:0], ssi_d_s};
          bit_d   = bit_q + 1'b1;
          cnt_d   = HP_LOAD;
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_MONO: begin
        if (cnt_q == '0) begin
          pos_d      = decoded;
          pv_d       = 1'b1;
          seq_d      = seq_q + 4'd1;
          line_err_d = ~line_ok_q;
          mono_err_d = ~ssi_d_s;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ssi_c       = ssi_c_q;
  assign busy        = busy_w;
  assign position    = pos_q;
  assign pos_valid   = pv_q;
  assign seq_cnt     = seq_q;
  assign line_err    = line_err_q;
  assign mono_err    = mono_err_q;
  assign overrun_err = overrun_q;

endmodule

// File: tb/tb_ssi_abs_encoder_master.sv
// Self-checking bench for ssi_abs_encoder_master. A behavioural SSI encoder
// drives ssi_d from the observed ssi_c edges; expectations come from the frame
// word, the latency formula and simple counters kept here.
module tb_ssi_abs_encoder_master;

  localparam int DB   = 12;
  localparam int HP   = 4;
  localparam int MONO = 40;
  localparam int RP   = 500;
  localparam int LAT  = (2 * DB + 1) * HP + MONO + 1;

  logic          clk_100m = 1'b0;
  logic          rst_n_syn;
  logic          auto_en;
  logic          read_req;
  logic          err_clr;
  logic          ssi_d = 1'b1;
  logic          ssi_c;
  logic          busy;
  logic [DB-1:0] position;
  logic          pos_valid;
  logic [3:0]    seq_cnt;
  logic          line_err;
  logic          mono_err;
  logic          overrun_err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int exp_seq     = 0;

  ssi_abs_encoder_master #(
    .DATA_BITS  (DB),
    .HALF_PERIOD(HP),
    .READ_PERIOD(RP),
    .MONO_CYCLES(MONO)
  ) dut (
    .clk_100m   (clk_100m),
    .rst_n_syn  (rst_n_syn),
    .auto_en    (auto_en),
    .read_req   (read_req),
    .err_clr    (err_clr),
    .ssi_d      (ssi_d),
    .ssi_c      (ssi_c),
    .busy       (busy),
    .position   (position),
    .pos_valid  (pos_valid),
    .seq_cnt    (seq_cnt),
    .line_err   (line_err),
    .mono_err   (mono_err),
    .overrun_err(overrun_err)
  );

  always #5 clk_100m = ~clk_100m;

  always @(posedge clk_100m) cyc <= cyc + 1;

  // Encoder model: presents the next bit MSB-first on each rising ssi_c edge
  // after the start edge; outside a frame the line sits at line_level.
  logic [DB-1:0] enc_word   = '0;
  logic          line_level = 1'b1;
  logic          enc_prev   = 1'b1;
  logic          in_frame   = 1'b0;
  int            enc_rise   = 0;
  int            rise_cnt   = 0;
  int            fall_cnt   = 0;

  always @(negedge clk_100m) begin
    if (!rst_n_syn) begin
      enc_prev = 1'b1;
      in_frame = 1'b0;
      enc_rise = 0;
      ssi_d    = line_level;
    end else begin
      if (enc_prev && !ssi_c) begin
        fall_cnt++;
        if (!in_frame) begin
          in_frame = 1'b1;
          enc_rise = 0;
        end
      end
      if (!enc_prev && ssi_c) begin
        rise_cnt++;
        if (in_frame) begin
          if (enc_rise < DB) ssi_d = enc_word[DB-1-enc_rise];
          else               in_frame = 1'b0;
          enc_rise++;
        end
      end
      if (!in_frame) ssi_d = line_level;
      enc_prev = ssi_c;
    end
  end

  // Publication monitor: records every pos_valid pulse and its context.
  int            pv_count  = 0;
  int            pv_double = 0;
  logic          pv_prev   = 1'b0;
  int            pv_cyc  [64];
  logic [DB-1:0] pv_pos  [64];
  logic [3:0]    pv_seq  [64];
  logic          pv_line [64];
  logic          pv_mono [64];
  logic          pv_busy [64];

  always @(negedge clk_100m) begin
    if (pos_valid === 1'b1) begin
      if (pv_prev) pv_double++;
      if (pv_count < 64) begin
        pv_cyc[pv_count]  = cyc;
        pv_pos[pv_count]  = position;
        pv_seq[pv_count]  = seq_cnt;
        pv_line[pv_count] = line_err;
        pv_mono[pv_count] = mono_err;
        pv_busy[pv_count] = busy;
      end
      pv_count++;
    end
    pv_prev = (pos_valid === 1'b1);
  end

  // Expected published value for a transmitted word.
  function automatic logic [DB-1:0] exp_pos(input logic [DB-1:0] w);
`ifdef SSI_GRAY_DECODE_EN
    logic [DB-1:0] b;
    b = '0;
    for (int s = 0; s < DB; s++) b = b ^ (w >> s);
    return b;
`else
    return w;
`endif
  endfunction

  task automatic pulse_read(output int tcyc);
    @(negedge clk_100m);
    read_req = 1'b1;
    @(posedge clk_100m);
    #1 tcyc = cyc;
    @(negedge clk_100m);
    read_req = 1'b0;
  endtask

  task automatic wait_pv(input int n0, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk_100m);
      #1;
      if (pv_count > n0) got = 1'b1;
    end
  endtask

  task automatic run_frame(input logic [DB-1:0] w, output int tcyc, output int n0, output bit got);
    enc_word = w;
    n0       = pv_count;
    pulse_read(tcyc);
    wait_pv(n0, LAT + 100, got);
  endtask

  task automatic test_reset();
    vectors++; if (ssi_c !== 1'b1) begin miscompares++; $display("FAIL reset_ssi_c: got %b want 1", ssi_c); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (position !== '0) begin miscompares++; $display("FAIL reset_position: got %h want 0", position); end
    vectors++; if (seq_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_seq: got %0d want 0", seq_cnt); end
    vectors++; if ({pos_valid, line_err, mono_err, overrun_err} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_flags: got %b want 0000", {pos_valid, line_err, mono_err, overrun_err});
    end
    repeat (50) @(negedge clk_100m);
    #1;
    vectors++; if (pv_count !== 0) begin miscompares++; $display("FAIL reset_idle_pv: got %0d pulses want 0", pv_count); end
  endtask

  task automatic test_single_frame();
    logic [DB-1:0] words [3];
    words[0] = 12'hA5C;
    words[1] = DB'($urandom);
    words[2] = DB'($urandom);
    for (int k = 0; k < 3; k++) begin
      int tcyc, n0, r0, f0;
      bit got;
      r0 = rise_cnt;
      f0 = fall_cnt;
      run_frame(words[k], tcyc, n0, got);
      vectors++;
      if (!got) begin
        miscompares++; $display("FAIL single_timeout: word %h, no pos_valid", words[k]);
      end else begin
        exp_seq = (exp_seq + 1) % 16;
        vectors++; if (pv_cyc[n0] - tcyc !== LAT) begin miscompares++; $display("FAIL single_latency: got %0d want %0d", pv_cyc[n0] - tcyc, LAT); end
        vectors++; if (pv_pos[n0] !== exp_pos(words[k])) begin miscompares++; $display("FAIL single_position: got %h want %h", pv_pos[n0], exp_pos(words[k])); end
        vectors++; if (pv_seq[n0] !== 4'(exp_seq)) begin miscompares++; $display("FAIL single_seq: got %0d want %0d", pv_seq[n0], exp_seq); end
        vectors++; if ({pv_line[n0], pv_mono[n0]} !== 2'b00) begin miscompares++; $display("FAIL single_errs: got %b want 00", {pv_line[n0], pv_mono[n0]}); end
        vectors++; if (rise_cnt - r0 !== DB + 1) begin miscompares++; $display("FAIL single_rises: got %0d want %0d", rise_cnt - r0, DB + 1); end
        vectors++; if (fall_cnt - f0 !== DB + 1) begin miscompares++; $display("FAIL single_falls: got %0d want %0d", fall_cnt - f0, DB + 1); end
        vectors++; if (pv_busy[n0] !== 1'b0) begin miscompares++; $display("FAIL single_busy_end: got %b want 0", pv_busy[n0]); end
      end
      repeat (10) @(negedge clk_100m);
    end
  endtask

  task automatic test_auto_period();
    int n0;
    bit got;
    logic [DB-1:0] cur;
    n0       = pv_count;
    cur      = DB'($urandom);
    enc_word = cur;
    @(negedge clk_100m);
    auto_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_pv(n0 + k, RP + 200, got);
      vectors++;
      if (!got) begin
        miscompares++; $display("FAIL auto_timeout: frame %0d missing", k);
      end else begin
        exp_seq = (exp_seq + 1) % 16;
        vectors++; if (pv_pos[n0+k] !== exp_pos(cur)) begin miscompares++; $display("FAIL auto_position: got %h want %h", pv_pos[n0+k], exp_pos(cur)); end
        vectors++; if (pv_seq[n0+k] !== 4'(exp_seq)) begin miscompares++; $display("FAIL auto_seq: got %0d want %0d", pv_seq[n0+k], exp_seq); end
        vectors++; if (pv_busy[n0+k] !== 1'b0) begin miscompares++; $display("FAIL auto_busy_between: got %b want 0", pv_busy[n0+k]); end
        if (k > 0) begin
          vectors++; if (pv_cyc[n0+k] - pv_cyc[n0+k-1] !== RP) begin
            miscompares++; $display("FAIL auto_spacing: got %0d want %0d", pv_cyc[n0+k] - pv_cyc[n0+k-1], RP);
          end
        end
        cur      = DB'($urandom);
        enc_word = cur;
      end
    end
    auto_en = 1'b0;
    repeat (RP + 200) @(negedge clk_100m);
    #1;
    vectors++; if (pv_count !== n0 + 5) begin miscompares++; $display("FAIL auto_disable: got %0d frames want %0d", pv_count - n0, 5); end
  endtask

  task automatic test_overrun();
    int t0, t1, n0;
    bit got;
    logic [DB-1:0] w;
    w        = DB'($urandom);
    enc_word = w;
    n0       = pv_count;
    pulse_read(t0);
    repeat (30) @(negedge clk_100m);
    vectors++; if (overrun_err !== 1'b0) begin miscompares++; $display("FAIL overrun_before: got %b want 0", overrun_err); end
    pulse_read(t1);
    vectors++; if (overrun_err !== 1'b1) begin miscompares++; $display("FAIL overrun_set: got %b want 1", overrun_err); end
    wait_pv(n0, LAT + 100, got);
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL overrun_timeout: no pos_valid");
    end else begin
      exp_seq = (exp_seq + 1) % 16;
      vectors++; if (pv_cyc[n0] - t0 !== LAT) begin miscompares++; $display("FAIL overrun_latency: got %0d want %0d", pv_cyc[n0] - t0, LAT); end
      vectors++; if (pv_pos[n0] !== exp_pos(w)) begin miscompares++; $display("FAIL overrun_position: got %h want %h", pv_pos[n0], exp_pos(w)); end
      vectors++; if (pv_seq[n0] !== 4'(exp_seq)) begin miscompares++; $display("FAIL overrun_seq: got %0d want %0d", pv_seq[n0], exp_seq); end
    end
    repeat (300) @(negedge clk_100m);
    #1;
    vectors++; if (pv_count !== n0 + 1) begin miscompares++; $display("FAIL overrun_extra_frame: got %0d frames want 1", pv_count - n0); end
    vectors++; if (overrun_err !== 1'b1) begin miscompares++; $display("FAIL overrun_sticky: got %b want 1", overrun_err); end
    @(negedge clk_100m); err_clr = 1'b1;
    @(negedge clk_100m); err_clr = 1'b0;
    vectors++; if (overrun_err !== 1'b0) begin miscompares++; $display("FAIL overrun_clear: got %b want 0", overrun_err); end

    // New overrun and clear in the same cycle: the set must win.
    w        = DB'($urandom);
    enc_word = w;
    n0       = pv_count;
    pulse_read(t0);
    repeat (20) @(negedge clk_100m);
    read_req = 1'b1;
    err_clr  = 1'b1;
    @(negedge clk_100m);
    read_req = 1'b0;
    err_clr  = 1'b0;
    vectors++; if (overrun_err !== 1'b1) begin miscompares++; $display("FAIL overrun_set_wins: got %b want 1", overrun_err); end
    wait_pv(n0, LAT + 100, got);
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL overrun2_timeout: no pos_valid");
    end else begin
      exp_seq = (exp_seq + 1) % 16;
      vectors++; if (pv_pos[n0] !== exp_pos(w)) begin miscompares++; $display("FAIL overrun2_position: got %h want %h", pv_pos[n0], exp_pos(w)); end
    end
    @(negedge clk_100m); err_clr = 1'b1;
    @(negedge clk_100m); err_clr = 1'b0;
    repeat (10) @(negedge clk_100m);
  endtask

  task automatic test_line_fault();
    int tcyc, n0;
    bit got;
    logic [DB-1:0] w;
    line_level = 1'b0;
    repeat (10) @(negedge clk_100m);
    w = DB'($urandom);
    run_frame(w, tcyc, n0, got);
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL fault_timeout: no pos_valid");
    end else begin
      exp_seq = (exp_seq + 1) % 16;
      vectors++; if ({pv_line[n0], pv_mono[n0]} !== 2'b11) begin miscompares++; $display("FAIL fault_errs: got %b want 11", {pv_line[n0], pv_mono[n0]}); end
      vectors++; if (pv_pos[n0] !== exp_pos(w)) begin miscompares++; $display("FAIL fault_position: got %h want %h", pv_pos[n0], exp_pos(w)); end
    end
    line_level = 1'b1;
    repeat (10) @(negedge clk_100m);
    w = DB'($urandom);
    run_frame(w, tcyc, n0, got);
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL clean_timeout: no pos_valid");
    end else begin
      exp_seq = (exp_seq + 1) % 16;
      vectors++; if ({pv_line[n0], pv_mono[n0]} !== 2'b00) begin miscompares++; $display("FAIL clean_errs: got %b want 00", {pv_line[n0], pv_mono[n0]}); end
      vectors++; if (pv_pos[n0] !== exp_pos(w)) begin miscompares++; $display("FAIL clean_position: got %h want %h", pv_pos[n0], exp_pos(w)); end
    end
    repeat (10) @(negedge clk_100m);
  endtask

  task automatic test_reset_midframe();
    int tcyc, n0, f0;
    bit got;
    logic [DB-1:0] w;
    enc_word = DB'($urandom);
    n0       = pv_count;
    f0       = fall_cnt;
    pulse_read(tcyc);
    for (int i = 0; i < 300 && (fall_cnt - f0) < 7; i++) @(negedge clk_100m);
    vectors++; if (fall_cnt - f0 < 7) begin miscompares++; $display("FAIL midreset_reach: got %0d falls want 7", fall_cnt - f0); end
    @(posedge clk_100m);
    #2 rst_n_syn = 1'b0;
    #1;
    vectors++; if (ssi_c !== 1'b1) begin miscompares++; $display("FAIL midreset_ssi_c: got %b want 1", ssi_c); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b want 0", busy); end
    vectors++; if (position !== '0) begin miscompares++; $display("FAIL midreset_position: got %h want 0", position); end
    vectors++; if (seq_cnt !== 4'd0) begin miscompares++; $display("FAIL midreset_seq: got %0d want 0", seq_cnt); end
    vectors++; if ({pos_valid, line_err, mono_err, overrun_err} !== 4'b0000) begin
      miscompares++; $display("FAIL midreset_flags: got %b want 0000", {pos_valid, line_err, mono_err, overrun_err});
    end
    repeat (3) @(negedge clk_100m);
    rst_n_syn = 1'b1;
    exp_seq   = 0;
    repeat (300) @(negedge clk_100m);
    #1;
    vectors++; if (pv_count !== n0) begin miscompares++; $display("FAIL midreset_no_pv: got %0d pulses want 0", pv_count - n0); end
    w = DB'($urandom);
    run_frame(w, tcyc, n0, got);
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL postreset_timeout: no pos_valid");
    end else begin
      exp_seq = (exp_seq + 1) % 16;
      vectors++; if (pv_pos[n0] !== exp_pos(w)) begin miscompares++; $display("FAIL postreset_position: got %h want %h", pv_pos[n0], exp_pos(w)); end
      vectors++; if (pv_seq[n0] !== 4'(exp_seq)) begin miscompares++; $display("FAIL postreset_seq: got %0d want %0d", pv_seq[n0], exp_seq); end
      vectors++; if (pv_cyc[n0] - tcyc !== LAT) begin miscompares++; $display("FAIL postreset_latency: got %0d want %0d", pv_cyc[n0] - tcyc, LAT); end
    end
    repeat (10) @(negedge clk_100m);
  endtask

  task automatic test_gray();
    int tcyc, n0;
    bit got;
    logic [DB-1:0] want;
`ifdef SSI_GRAY_DECODE_EN
    want = 12'hFFF;
`else
    want = 12'h800;
`endif
    run_frame(12'h800, tcyc, n0, got);
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL gray_timeout: no pos_valid");
    end else begin
      exp_seq = (exp_seq + 1) % 16;
      vectors++; if (pv_pos[n0] !== want) begin miscompares++; $display("FAIL gray_position: got %h want %h", pv_pos[n0], want); end
    end
    repeat (10) @(negedge clk_100m);
  endtask

  task automatic test_pulse_width();
    vectors++; if (pv_double !== 0) begin miscompares++; $display("FAIL pv_width: got %0d multi-cycle pulses want 0", pv_double); end
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n_syn = 1'b0;
    auto_en   = 1'b0;
    read_req  = 1'b0;
    err_clr   = 1'b0;
    repeat (4) @(negedge clk_100m);
    rst_n_syn = 1'b1;
    #1;
    test_reset();
    test_single_frame();
    test_auto_period();
    test_overrun();
    test_line_fault();
    test_reset_midframe();
    test_gray();
    test_pulse_width();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
